// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the round-robin select arbiter and the 4:1 option mux consumer.
// The lock signal is present only when MUX_SEL_ARB_LOCK_EN is defined.
interface mux_sel_arbiter_if #(
  parameter int WIDTH_OP = 4,
  parameter int WIDTH_IN = 2
);
  logic [WIDTH_OP-1:0] req;
  logic                ready;
  logic [WIDTH_IN-1:0] sel;
  logic                valid;
  logic [WIDTH_OP-1:0] grant;
`ifdef MUX_SEL_ARB_LOCK_EN
  logic                lock;
`endif

  modport master (
    input  req,
    input  ready,
`ifdef MUX_SEL_ARB_LOCK_EN
    input  lock,
`endif
    output sel,
    output valid,
    output grant
  );

  modport slave (
    output req,
    output ready,
`ifdef MUX_SEL_ARB_LOCK_EN
    output lock,
`endif
    input  sel,
    input  valid,
    input  grant
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter producing a registered, handshake-held select for the option mux.
// Optional burst ownership via the lock input is enabled by defining MUX_SEL_ARB_LOCK_EN.
module mux_sel_arbiter #(
  parameter int WIDTH_OP = 4,
  parameter int WIDTH_IN = 2
) (
  input logic               clk,
  input logic               rst,
  mux_sel_arbiter_if.master bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [WIDTH_IN-1:0] LAST_IDX = WIDTH_IN'(WIDTH_OP - 1);
  localparam logic [WIDTH_IN:0]   NUM_OP   = (WIDTH_IN+1)'(WIDTH_OP);
  localparam logic [WIDTH_OP-1:0] ONE_HOT0 = WIDTH_OP'(1);

  logic [0:0]          state_q, state_d;
  logic [WIDTH_IN-1:0] sel_q, sel_d;
  logic [WIDTH_IN-1:0] ptr_q, ptr_d;
  logic                valid_q, valid_d;
  logic [WIDTH_OP-1:0] grant_q, grant_d;

  logic [WIDTH_IN-1:0] nextPtr;
  logic [WIDTH_IN-1:0] searchStart;
  logic [WIDTH_IN:0]   cand;
  logic [WIDTH_IN-1:0] winner;
  logic                found;
  logic                transfer;
  logic                holdLock;

  // Pointer after the current grant completes; explicit wrap keeps it below WIDTH_OP.
  assign nextPtr     = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
  assign searchStart = (state_q == GRANT) ? nextPtr : ptr_q;
  assign transfer    = valid_q && bus.ready;

`ifdef MUX_SEL_ARB_LOCK_EN
  assign holdLock = bus.lock && bus.req[sel_q];
`else
  assign holdLock = 1'b0;
`endif

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < WIDTH_OP; i++) begin
      cand = {1'b0, searchStart} + (WIDTH_IN+1)'(i);
      if (cand >= NUM_OP) begin
        cand = cand - NUM_OP;
      end
      if (!found && bus.req[cand[WIDTH_IN-1:0]]) begin
        found  = 1'b1;
        winner = cand[WIDTH_IN-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = winner;
          grant_d = ONE_HOT0 << winner;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A locked owner that still requests keeps the grant and the pointer.
        if (transfer && !holdLock) begin
          ptr_d = nextPtr;
          if (found) begin
            sel_d   = winner;
            grant_d = ONE_HOT0 << winner;
          end else begin
            valid_d = 1'b0;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.grant = grant_q;
endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that sits directly upstream of the 4:1 option multiplexer and generates its select. Each of up to WIDTH_OP sources raises a request. The arbiter registers a fair grant and drives the winning index onto `sel`, which connects to the mux select input. It holds that select stable under a valid/ready handshake until the downstream consumer accepts the selected option.

## Interface
- WIDTH_OP, default 4: number of requesters/options; legal range 2..2**WIDTH_IN.
- WIDTH_IN, default 2: select width; matches the mux select width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  WIDTH_OP  per-source request, level-sensitive.
- ready  in  1  downstream accepts the currently selected option this cycle.
- sel  out  WIDTH_IN  registered index of the granted source; drives the mux select.
- valid  out  1  registered; `sel` is meaningful and a transfer is pending.
- grant  out  WIDTH_OP  registered one-hot grant, equal to 1 << sel while valid, else 0.
- lock  in  1  present only with MUX_SEL_ARB_LOCK_EN; requests that the current grant be kept.

## Operation
- Reset values: sel=0, valid=0, grant=0, priority pointer ptr=0, state=IDLE.
- Reset asserted mid-GRANT: all outputs return to their reset values immediately. The pending transfer is dropped.
- FSM has two states: IDLE and GRANT.
- IDLE behaviour:
  - If any req bit is 1, select the first set bit searching from index ptr upward, wrapping WIDTH_OP-1 -> 0.
  - Register that index into sel, set grant and valid=1, and move to GRANT.
  - If no req bit is set, outputs stay at valid=0, grant=0, and sel keeps its last value.
- GRANT, no transfer (valid=1, ready=0):
  - sel, grant and valid are held unchanged.
  - A requester dropping its req does not cancel its grant.
- GRANT, transfer (valid=1 and ready=1):
  - ptr <= sel+1, wrapping to 0 after WIDTH_OP-1.
  - Arbitration over the current req runs in the same cycle, searching from the new ptr.
  - If a winner exists, the new sel/grant are registered and valid stays 1 (back-to-back).
  - If no winner exists, valid is cleared and the FSM returns to IDLE.
- sel never exceeds WIDTH_OP-1, including when WIDTH_OP is not a power of two.
- req bits at indices >= WIDTH_OP do not exist. Indices in the search always wrap modulo WIDTH_OP.

## Timing
- Request-to-valid latency is 1 cycle: req sampled at edge N gives valid=1 after edge N.
- Throughput is at most one transfer per cycle. With ready held high, sel updates every cycle.
- The transfer completes on the edge where valid and ready are both 1. The consumer samples the mux output in that cycle.
- ready has no combinational path to sel, valid or grant. All outputs come straight from flops.
- Fairness: under continuous requests from all sources, each source is granted exactly once per WIDTH_OP transfers.

## Configuration
- MUX_SEL_ARB_LOCK_EN defined:
  - The `lock` port exists.
  - On a transfer edge with lock=1 and req[sel]=1, sel/grant stay the same, valid stays 1 and ptr is not advanced. This supports burst ownership.
  - If lock=1 but req[sel]=0, normal rotation applies.
- MUX_SEL_ARB_LOCK_EN undefined:
  - The `lock` port is absent.
  - Every transfer rotates the pointer as described above.

## Test plan
- Reset: assert rst with req=4'b1111 -> sel=0, valid=0, grant=0 while rst=1. After release, the first grant is sel=0.
- Single requester: req=4'b0100, ready=1 -> valid=1 one cycle later with sel=2 and grant=4'b0100. After one transfer, valid=0 (req dropped).
- Full load rotation: req=4'b1111, ready=1 held -> sel sequence 0,1,2,3,0,1 on consecutive cycles, valid constantly 1.
- Backpressure: req=4'b0110, ready=0 for 3 cycles -> sel=1 and grant=4'b0010 held stable. Then ready=1 for 1 cycle -> next sel=2.
- Reset mid-operation: rst asserted while valid=1 and sel=3 -> valid=0 and sel=0 immediately (asynchronous). After release with req=4'b1111, sel=0.
- Lock (MUX_SEL_ARB_LOCK_EN defined): req=4'b1111, grant at sel=1, lock=1, ready=1 for 3 cycles -> sel=1 on all 3 transfers. Then lock=0 -> sel=2.
